modulo_escalonador_rolhas: RTL and testbench

- Owns the cork stock counters: secondary buffer (operator-loaded, 0..99) and principal buffer (feeds the sealing station).
- Arbitrates between two requesters of the secondary buffer: operator batch load and automatic refill of the principal buffer.
- Sequences the refill one cork per clock and decrements the principal stock on every sealing event.
- Drives the `ro` (no corks) flag to the fill/seal MEF and the counts to the display path.

---
 rtl/modulo_escalonador_rolhas_pkg.sv | 11 +
 rtl/modulo_escalonador_rolhas_min3.sv | 19 +
 rtl/modulo_escalonador_rolhas.sv | 102 ++++++++++
 tb/tb_modulo_escalonador_rolhas.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/modulo_escalonador_rolhas_pkg.sv
// pkg_rolhas: shared state codes, default capacities and counter widths for the cork scheduler
package pkg_rolhas;
  localparam int W_SEC = 7;
  localparam int W_PRI = 5;
  typedef enum logic [1:0] {IDLE = 2'b00, CARGA = 2'b01, TRANSF = 2'b10, FIM = 2'b11} estado_t;
  localparam logic [W_SEC-1:0] CAP_SEC_D = 7'd99;
  localparam logic [W_PRI-1:0] CAP_PRI_D = 5'd20;
  localparam logic [W_PRI-1:0] INIT_PRI_D = 5'd20;
  localparam logic [W_PRI-1:0] MIN_PRI_D = 5'd5;
  localparam logic [W_PRI-1:0] LOTE_D = 5'd15;
endpackage

// File: rtl/modulo_escalonador_rolhas_min3.sv
// modulo_min3_rolhas: size of the next refill batch = min(LOTE, secondary stock, principal free room)
module modulo_min3_rolhas
  import pkg_rolhas::*;
#(
  parameter logic [W_PRI-1:0] LOTE = LOTE_D,
  parameter logic [W_PRI-1:0] CAP_PRI = CAP_PRI_D
) (
  input  logic [W_SEC-1:0] sec_count,
  input  logic [W_PRI-1:0] pri_count,
  output logic [W_PRI-1:0] rem_ini
);
  logic [W_SEC-1:0] vaga, a, b;
  always_comb begin
    vaga = W_SEC'(CAP_PRI - pri_count);
    a = W_SEC'(LOTE) < sec_count ? W_SEC'(LOTE) : sec_count;
    b = a < vaga ? a : vaga;
  end
  assign rem_ini = W_PRI'(b);
endmodule

// File: rtl/modulo_escalonador_rolhas.sv
// modulo_escalonador_rolhas: cork stock owner, arbitrating operator loads against principal refills.
// Define ROLHAS_PRIORIDADE_ROTATIVA_EN to alternate grants on ties instead of fixed refill priority.
module modulo_escalonador_rolhas
  import pkg_rolhas::*;
#(
  parameter logic [W_SEC-1:0] CAP_SEC = CAP_SEC_D,
  parameter logic [W_PRI-1:0] CAP_PRI = CAP_PRI_D,
  parameter logic [W_PRI-1:0] INIT_PRI = INIT_PRI_D,
  parameter logic [W_PRI-1:0] MIN_PRI = MIN_PRI_D,
  parameter logic [W_PRI-1:0] LOTE = LOTE_D
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             habilita,
  input  logic             consumo,
  input  logic             op_req,
  input  logic [W_SEC-1:0] op_qtd,
  output logic             op_ack,
  output logic             op_nack,
  output logic [W_SEC-1:0] sec_count,
  output logic [W_PRI-1:0] pri_count,
  output logic             ro,
  output logic             transf_ativa,
  output logic             transf_fim,
  output logic [1:0]       estado
);
  estado_t st;
  logic [W_PRI-1:0] rem, rem_ini, pri_nxt;
  logic [W_SEC:0] soma;
  logic pedido_auto, ganha_auto, inc, dec;
  modulo_min3_rolhas #(.LOTE(LOTE), .CAP_PRI(CAP_PRI)) u_min3 (
    .sec_count(sec_count),
    .pri_count(pri_count),
    .rem_ini(rem_ini)
  );
  assign pedido_auto = (pri_count < MIN_PRI) && (sec_count != '0);
`ifdef ROLHAS_PRIORIDADE_ROTATIVA_EN
  logic ultimo;
  // ultimo: 1 = refill got the last grant, so the operator wins the next tie
  assign ganha_auto = pedido_auto && (!op_req || !ultimo);
  always_ff @(posedge clk or negedge clr)
    if (!clr) ultimo <= 1'b0;
    else if (st == IDLE && habilita && (pedido_auto || op_req)) ultimo <= ganha_auto;
`else
  assign ganha_auto = pedido_auto;
`endif
  // A cork arriving and a cork sealed in the same cycle cancel out
  always_comb begin
    inc = (st == TRANSF);
    dec = consumo && (pri_count != '0 || inc);
    pri_nxt = (inc && !dec) ? pri_count + 1'b1 : (dec && !inc) ? pri_count - 1'b1 : pri_count;
    soma = {1'b0, sec_count} + {1'b0, op_qtd};
  end
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      st <= IDLE;
      sec_count <= '0;
      pri_count <= INIT_PRI;
      rem <= '0;
      op_ack <= 1'b0;
      op_nack <= 1'b0;
      transf_fim <= 1'b0;
      ro <= 1'b0;
    end else begin
      op_ack <= 1'b0;
      op_nack <= 1'b0;
      transf_fim <= 1'b0;
      pri_count <= pri_nxt;
      ro <= (pri_nxt == '0);
      case (st)
        IDLE: begin
          if (habilita && ganha_auto) begin
            st <= TRANSF;
            rem <= rem_ini;
          end else if (habilita && op_req) begin
            st <= CARGA;
          end
        end
        CARGA: begin
          st <= IDLE;
          if (soma > {1'b0, CAP_SEC}) begin
            op_nack <= 1'b1;
          end else begin
            op_ack <= 1'b1;
            sec_count <= soma[W_SEC-1:0];
          end
        end
        TRANSF: begin
          sec_count <= sec_count - 1'b1;
          rem <= rem - 1'b1;
          if (rem == W_PRI'(1)) begin
            st <= FIM;
            transf_fim <= 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
  assign transf_ativa = (st == TRANSF);
  assign estado = st;
endmodule

// File: tb/tb_modulo_escalonador_rolhas.sv
// tb_modulo_escalonador_rolhas: directed scenarios plus random traffic against a stock-level model
module tb_modulo_escalonador_rolhas;
  logic clk = 0, clr = 1, habilita = 0, consumo = 0, op_req = 0;
  logic [6:0] op_qtd = 0;
  logic op_ack, op_nack, ro, transf_ativa, transf_fim;
  logic [6:0] sec_count;
  logic [4:0] pri_count;
  logic [1:0] estado;
  int vectors = 0, miscompares = 0;
  int m_st, m_sec, m_pri, m_rem, m_ult;
  bit m_ack, m_nack, m_fim, m_ro;
  int n;

  modulo_escalonador_rolhas dut (
    .clk(clk), .clr(clr), .habilita(habilita), .consumo(consumo), .op_req(op_req),
    .op_qtd(op_qtd), .op_ack(op_ack), .op_nack(op_nack), .sec_count(sec_count),
    .pri_count(pri_count), .ro(ro), .transf_ativa(transf_ativa), .transf_fim(transf_fim),
    .estado(estado)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic compare();
    vectors++;
    if (estado !== 2'(m_st) || sec_count !== 7'(m_sec) || pri_count !== 5'(m_pri) || ro !== m_ro ||
        op_ack !== m_ack || op_nack !== m_nack || transf_fim !== m_fim || transf_ativa !== (m_st == 2)) begin
      miscompares++;
      $display("FAIL cycle @%0t: dut st=%0d sec=%0d pri=%0d ro=%b ack=%b nack=%b fim=%b ativa=%b; expected st=%0d sec=%0d pri=%0d ro=%b ack=%b nack=%b fim=%b ativa=%b",
               $time, estado, sec_count, pri_count, ro, op_ack, op_nack, transf_fim, transf_ativa,
               m_st, m_sec, m_pri, m_ro, m_ack, m_nack, m_fim, m_st == 2);
    end
  endtask

  task automatic m_reset();
    m_st = 0; m_sec = 0; m_pri = 20; m_rem = 0; m_ult = 0;
    m_ack = 0; m_nack = 0; m_fim = 0; m_ro = 0;
  endtask

  task automatic model_step();
    int pn, s;
    bit inc, win;
    inc = (m_st == 2);
    pn = m_pri;
    if (inc && !consumo) pn = m_pri + 1;
    else if (!inc && consumo && m_pri > 0) pn = m_pri - 1;
    m_ack = 0; m_nack = 0; m_fim = 0;
    case (m_st)
      0: if (habilita) begin
        win = (m_pri < 5) && (m_sec > 0);
`ifdef ROLHAS_PRIORIDADE_ROTATIVA_EN
        win = win && (!op_req || m_ult == 0);
`endif
        if (win) begin
          m_st = 2;
          m_rem = 15;
          if (m_sec < m_rem) m_rem = m_sec;
          if (20 - m_pri < m_rem) m_rem = 20 - m_pri;
          m_ult = 1;
        end else if (op_req) begin
          m_st = 1;
          m_ult = 0;
        end
      end
      1: begin
        s = m_sec + int'(op_qtd);
        if (s > 99) m_nack = 1;
        else begin m_ack = 1; m_sec = s; end
        m_st = 0;
      end
      2: begin
        m_sec--; m_rem--;
        if (m_rem == 0) begin m_st = 3; m_fim = 1; end
      end
      default: m_st = 0;
    endcase
    m_pri = pn;
    m_ro = (pn == 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare();
    if (m_ack || m_nack) op_req = 0;
  endtask

  task automatic do_reset();
    op_req = 0; consumo = 0;
    clr = 0;
    m_reset();
    #1;
    compare();
    chk("rst_estado", estado, 0);
    chk("rst_sec", sec_count, 0);
    chk("rst_pri", pri_count, 20);
    chk("rst_ro", ro, 0);
    @(negedge clk);
    clr = 1;
  endtask

  task automatic load(int q);
    bit done;
    done = 0;
    op_req = 1; op_qtd = 7'(q);
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      done = m_ack || m_nack;
    end
    if (!done) chk("load_timeout", 0, 1);
  endtask

  task automatic consume(int k);
    for (int i = 0; i < k; i++) begin
      consumo = 1;
      tick();
    end
    consumo = 0;
  endtask

  task automatic run_fim(input bit eat, output int nativa);
    nativa = 0;
    for (int i = 0; i < 60; i++) begin
      consumo = eat && (m_st == 2);
      tick();
      if (transf_ativa) nativa++;
      if (m_fim) begin consumo = 0; return; end
    end
    consumo = 0;
    chk("fim_timeout", 0, 1);
  endtask

  task automatic to_idle();
    for (int i = 0; i < 5 && m_st != 0; i++) tick();
  endtask

  initial begin
    #2;
    do_reset();
    // operator loads: accept, reject on overflow, exact fill to capacity
    habilita = 1;
    load(40);
    chk("ack40", op_ack, 1);
    chk("sec40", sec_count, 40);
    chk("pri40", pri_count, 20);
    chk("idle40", estado, 0);
    load(50);
    load(10);
    chk("nack_overflow", op_nack, 1);
    chk("sec_kept90", sec_count, 90);
    load(9);
    chk("ack_fill99", op_ack, 1);
    chk("sec99", sec_count, 99);
    load(0);
    chk("ack_zero", op_ack, 1);
    // full batch refill from pri=4, sec=40
    do_reset();
    habilita = 1; load(40);
    habilita = 0; consume(16);
    chk("pri4", pri_count, 4);
    habilita = 1; run_fim(0, n);
    chk("ativa15", n, 15);
    chk("fim_pulse", transf_fim, 1);
    chk("pri19", pri_count, 19);
    chk("sec25", sec_count, 25);
    to_idle();
    // short refill limited by secondary stock
    do_reset();
    habilita = 1; load(2);
    habilita = 0; consume(17);
    habilita = 1; run_fim(0, n);
    chk("ativa2", n, 2);
    chk("pri5", pri_count, 5);
    chk("sec0", sec_count, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("no_rerefill", estado, 0);
    // sealing every transfer cycle keeps pri flat
    do_reset();
    habilita = 1; load(40);
    habilita = 0; consume(16);
    habilita = 1; run_fim(1, n);
    chk("eat_ativa15", n, 15);
    chk("eat_pri4", pri_count, 4);
    chk("eat_sec25", sec_count, 25);
    to_idle();
    // two ties in a row, separated by a habilita=0 window
    do_reset();
    habilita = 1; load(30);
    habilita = 0; consume(17);
    op_req = 1; op_qtd = 5;
    habilita = 1; tick();
    chk("tie1_refill", estado, 2);
    habilita = 0; run_fim(0, n);
    to_idle();
    chk("tie1_pri18", pri_count, 18);
    consume(14);
    habilita = 1; tick();
`ifdef ROLHAS_PRIORIDADE_ROTATIVA_EN
    chk("tie2_carga", estado, 1);
`else
    chk("tie2_refill", estado, 2);
`endif
    for (int i = 0; i < 80; i++) begin
      tick();
      if (!op_req && m_st == 0 && m_pri >= 5) break;
    end
    chk("tie_end_sec5", sec_count, 5);
    chk("tie_end_pri19", pri_count, 19);
    // drain with no secondary stock
    do_reset();
    habilita = 1; consume(20);
    chk("drain_pri0", pri_count, 0);
    chk("drain_ro", ro, 1);
    consume(1);
    chk("drain_floor", pri_count, 0);
    chk("drain_ro2", ro, 1);
    // asynchronous clear in the middle of a transfer
    do_reset();
    habilita = 1; load(40);
    habilita = 0; consume(16);
    habilita = 1;
    for (int i = 0; i < 5; i++) tick();
    chk("mid_ativa", transf_ativa, 1);
    habilita = 0;
    do_reset();
    // random traffic
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset();
      habilita = ($urandom % 8) != 0;
      consumo = ($urandom % 3) == 0;
      if (!op_req && ($urandom % 6) == 0) begin
        op_req = 1;
        op_qtd = ($urandom % 2) ? 7'($urandom_range(0, 20)) : 7'($urandom_range(0, 127));
      end
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
